dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Shares the single-port data block RAM (MEM_WIDTH address, 32-bit data, fixed read latency) between two requesters.
- Port 0 is the core load/store unit (LW/SW/FLW/FSW path); port 1 is the UART data loader and debug reader.
- Sequences every access: arbitrate, issue, wait out the read latency, return data.
- Round-robin on contention, so neither requester starves.

Parameters:
- MEM_WIDTH, 16, BRAM address width.
- DATA_WIDTH, 32, word width.
- READ_LATENCY, 1, BRAM cycles from sampled address to valid dout; legal range 1..4.

Ports:
- clk  in  1  system clock (clk_wiz output).
- rst_n  in  1  asynchronous active-low reset.
- req0  in  1  port 0 request; held until gnt0.
- we0  in  1  port 0 write enable (1 = store, 0 = load).
- addr0  in  MEM_WIDTH  port 0 word address.
- wdata0  in  DATA_WIDTH  port 0 store data.
- gnt0  out  1  port 0 grant, one-cycle pulse.
- rvalid0  out  1  port 0 read data valid, one-cycle pulse.
- req1, we1, addr1, wdata1, gnt1, rvalid1  same as port 0, for port 1.
- rdata  out  DATA_WIDTH  read data, shared; qualified by rvalid0 or rvalid1.
- bram_addr  out  MEM_WIDTH  to BRAM addra.
- bram_din  out  DATA_WIDTH  to BRAM dina.
- bram_we  out  1  to BRAM wea.
- bram_dout  in  DATA_WIDTH  from BRAM douta.
- busy  out  1  high whenever state is not IDLE.

Behaviour:
- Reset (async, rst_n=0):
  - All outputs go to 0; state goes to IDLE; last_winner goes to 1, so port 0 wins the first tie.
  - An access in flight is aborted: bram_we drops immediately and no rvalid is ever produced for it.
- States: IDLE, ISSUE, WAIT, DONE. All outputs are registered.
- IDLE, at the edge where req0|req1 is sampled:
  - Only one request: that port wins.
  - Both requests: the winner is the port that is not last_winner.
  - At that edge: bram_addr<=addr_w, bram_din<=wdata_w, bram_we<=we_w, gnt_w<=1, last_winner<=w, state<=ISSUE, lat_cnt<=READ_LATENCY-1.
- ISSUE (BRAM samples the address at this cycle's closing edge). At that edge:
  - gnt_w<=0 and bram_we<=0.
  - Write: state<=IDLE. A write takes 2 cycles; no rvalid is produced.
  - Read: state<=WAIT.
- WAIT:
  - lat_cnt decrements each cycle.
  - At the edge where lat_cnt==0: rdata<=bram_dout, rvalid_w<=1, state<=DONE.
  - Read total with READ_LATENCY=1: request sampled at edge T, gnt at T, rvalid at T+2.
- DONE: at the next edge rvalid_w<=0 and state<=IDLE. A new arbitration is sampled at that same edge, so back-to-back requests cost no extra idle cycle.
- Requester rules:
  - A port drops req (or changes it to a new access) in the cycle after it sees gnt.
  - req, we, addr and wdata are ignored outside IDLE.
- rdata holds its last value until the next read completes.
- Only the winning port's rvalid ever pulses; gnt0 and gnt1 are never high together.
- Address passes through unmodified; no wrap or offset arithmetic (the core computes the effective address).
- Same port re-requesting while the other is waiting: grants alternate strictly.

Optional Feature:
- Macro: DMEM_ARB_STATS_EN.
- Defined:
  - Adds outputs stat_gnt0, stat_gnt1 (16-bit, grants per port) and stat_conflict (16-bit, IDLE edges where both ports requested).
  - All three saturate at 16'hFFFF and reset to 0.
  - Adds input stat_clr (1-bit): synchronous clear of all three counters, with priority over increment.
- Not defined: these ports and counters do not exist; arbitration behaviour is identical.

Test Plan:
- Port 0 writes 0xDEADBEEF to 0x0010, then reads 0x0010 -> bram_we high for exactly 1 cycle; read gives rvalid0 two cycles after gnt0 with rdata=0xDEADBEEF; rvalid1 stays 0.
- After reset, req0 and req1 rise together, both reading (0x0001, 0x0002) -> gnt0 comes first, then gnt1; rdata returns 0x0001's contents, then 0x0002's.
- Both ports hold req continuously for 8 accesses -> grant order is 0,1,0,1,0,1,0,1; no gap cycle between DONE and the next gnt.
- READ_LATENCY=3, port 1 reads 0x00FF -> rvalid1 4 cycles after gnt1; busy high from the gnt1 edge through DONE.
- rst_n pulled low in the cycle after gnt0 for a read -> bram_we=0, gnt0=rvalid0=0 immediately; after release, state is IDLE and no stale rvalid0 appears.
- With DMEM_ARB_STATS_EN: 3 contended rounds of 2 accesses -> stat_conflict=3, stat_gnt0=3, stat_gnt1=3; stat_clr pulse zeroes all three.

Source files
------------

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port round-robin arbiter in front of the single-port
// data BRAM. Port 0 is the core load/store unit, port 1 the UART loader /
// debug reader. Every access goes IDLE -> ISSUE -> (WAIT -> DONE for reads).
// Optional grant/conflict statistics are compiled in with DMEM_ARB_STATS_EN.
module dmem_arbiter #(
    parameter int MEM_WIDTH    = 16,
    parameter int DATA_WIDTH   = 32,
    parameter int READ_LATENCY = 1     // 1..4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req0,
    input  logic                  we0,
    input  logic [MEM_WIDTH-1:0]  addr0,
    input  logic [DATA_WIDTH-1:0] wdata0,
    output logic                  gnt0,
    output logic                  rvalid0,
    input  logic                  req1,
    input  logic                  we1,
    input  logic [MEM_WIDTH-1:0]  addr1,
    input  logic [DATA_WIDTH-1:0] wdata1,
    output logic                  gnt1,
    output logic                  rvalid1,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic [MEM_WIDTH-1:0]  bram_addr,
    output logic [DATA_WIDTH-1:0] bram_din,
    output logic                  bram_we,
    input  logic [DATA_WIDTH-1:0] bram_dout,
`ifdef DMEM_ARB_STATS_EN
    input  logic                  stat_clr,
    output logic [15:0]           stat_gnt0,
    output logic [15:0]           stat_gnt1,
    output logic [15:0]           stat_conflict,
`endif
    output logic                  busy
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [1:0] LAT_INIT = 2'(READ_LATENCY - 1);

    logic [1:0] state;
    logic [1:0] lat_cnt;
    logic       last_winner;   // also identifies the port owning the access in flight

    logic arb_open;
    logic arb_go;
    logic win;
    logic conflict;

    // DONE accepts a new arbitration just like IDLE so back-to-back accesses lose no cycle
    always_comb begin
        arb_open = (state == S_IDLE) || (state == S_DONE);
        arb_go   = arb_open && (req0 || req1);
        conflict = arb_open && req0 && req1;
        win      = (req0 && req1) ? ~last_winner : req1;
    end

    assign busy = (state != S_IDLE);

    // Access sequencer: arbitrate, drive the BRAM, count out read latency, return data
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            lat_cnt     <= '0;
            last_winner <= 1'b1;
            gnt0        <= 1'b0;
            gnt1        <= 1'b0;
            rvalid0     <= 1'b0;
            rvalid1     <= 1'b0;
            rdata       <= '0;
            bram_addr   <= '0;
            bram_din    <= '0;
            bram_we     <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    rvalid0 <= 1'b0;
                    rvalid1 <= 1'b0;
                    if (arb_go) begin
                        bram_addr   <= win ? addr1  : addr0;
                        bram_din    <= win ? wdata1 : wdata0;
                        bram_we     <= win ? we1    : we0;
                        gnt0        <= ~win;
                        gnt1        <= win;
                        last_winner <= win;
                        lat_cnt     <= LAT_INIT;
                        state       <= S_ISSUE;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_ISSUE: begin
                    gnt0    <= 1'b0;
                    gnt1    <= 1'b0;
                    bram_we <= 1'b0;
                    // bram_we still holds the granted access type here
                    state   <= bram_we ? S_IDLE : S_WAIT;
                end
                S_WAIT: begin
                    if (lat_cnt == 2'd0) begin
                        rdata   <= bram_dout;
                        rvalid0 <= ~last_winner;
                        rvalid1 <= last_winner;
                        state   <= S_DONE;
                    end else begin
                        lat_cnt <= lat_cnt - 2'd1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef DMEM_ARB_STATS_EN
    // Saturating grant / conflict counters; clear wins over increment
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_gnt0     <= '0;
            stat_gnt1     <= '0;
            stat_conflict <= '0;
        end else if (stat_clr) begin
            stat_gnt0     <= '0;
            stat_gnt1     <= '0;
            stat_conflict <= '0;
        end else begin
            if (arb_go && !win && stat_gnt0 != 16'hFFFF)
                stat_gnt0 <= stat_gnt0 + 16'd1;
            if (arb_go && win && stat_gnt1 != 16'hFFFF)
                stat_gnt1 <= stat_gnt1 + 16'd1;
            if (conflict && stat_conflict != 16'hFFFF)
                stat_conflict <= stat_conflict + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: one READ_LATENCY=1 instance and one
// READ_LATENCY=3 instance, each with its own behavioural BRAM model.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    int          vectors = 0;
    int          errs = 0;

    always #5 clk = ~clk;

    // ---------------- instance A (READ_LATENCY = 1) ----------------
    logic        req0, we0, req1, we1;
    logic [15:0] addr0, addr1;
    logic [31:0] wdata0, wdata1;
    logic        gnt0, gnt1, rvalid0, rvalid1, bram_we, busy;
    logic [31:0] rdata, bram_din, bram_dout;
    logic [15:0] bram_addr;
`ifdef DMEM_ARB_STATS_EN
    logic        stat_clr;
    logic [15:0] stat_gnt0, stat_gnt1, stat_conflict;
`endif

    dmem_arbiter #(.MEM_WIDTH(16), .DATA_WIDTH(32), .READ_LATENCY(1)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .gnt0(gnt0), .rvalid0(rvalid0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .gnt1(gnt1), .rvalid1(rvalid1),
        .rdata(rdata), .bram_addr(bram_addr), .bram_din(bram_din), .bram_we(bram_we),
        .bram_dout(bram_dout),
`ifdef DMEM_ARB_STATS_EN
        .stat_clr(stat_clr), .stat_gnt0(stat_gnt0), .stat_gnt1(stat_gnt1),
        .stat_conflict(stat_conflict),
`endif
        .busy(busy)
    );

    logic [31:0] mem_a [0:255];
    always @(posedge clk) begin
        if (bram_we) mem_a[bram_addr[7:0]] <= bram_din;
        bram_dout <= mem_a[bram_addr[7:0]];
    end

    // ---------------- instance B (READ_LATENCY = 3) ----------------
    logic        b_req0, b_we0, b_req1, b_we1;
    logic [15:0] b_addr0, b_addr1;
    logic [31:0] b_wdata0, b_wdata1;
    logic        b_gnt0, b_gnt1, b_rvalid0, b_rvalid1, b_bram_we, b_busy;
    logic [31:0] b_rdata, b_bram_din, b_bram_dout;
    logic [15:0] b_bram_addr;
`ifdef DMEM_ARB_STATS_EN
    logic [15:0] b_stat_gnt0, b_stat_gnt1, b_stat_conflict;
`endif

    dmem_arbiter #(.MEM_WIDTH(16), .DATA_WIDTH(32), .READ_LATENCY(3)) dut3 (
        .clk(clk), .rst_n(rst_n),
        .req0(b_req0), .we0(b_we0), .addr0(b_addr0), .wdata0(b_wdata0), .gnt0(b_gnt0), .rvalid0(b_rvalid0),
        .req1(b_req1), .we1(b_we1), .addr1(b_addr1), .wdata1(b_wdata1), .gnt1(b_gnt1), .rvalid1(b_rvalid1),
        .rdata(b_rdata), .bram_addr(b_bram_addr), .bram_din(b_bram_din), .bram_we(b_bram_we),
        .bram_dout(b_bram_dout),
`ifdef DMEM_ARB_STATS_EN
        .stat_clr(1'b0), .stat_gnt0(b_stat_gnt0), .stat_gnt1(b_stat_gnt1),
        .stat_conflict(b_stat_conflict),
`endif
        .busy(b_busy)
    );

    logic [31:0] mem_b [0:255];
    logic [31:0] b_p1, b_p2;
    always @(posedge clk) begin
        if (b_bram_we) mem_b[b_bram_addr[7:0]] <= b_bram_din;
        b_p1        <= mem_b[b_bram_addr[7:0]];
        b_p2        <= b_p1;
        b_bram_dout <= b_p2;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem_a[i] = 32'h0;
            mem_b[i] = 32'h0;
        end
        mem_a[1] = 32'h1111_1111;
        mem_a[2] = 32'h2222_2222;
        mem_a[3] = 32'h3333_3333;
        mem_a[4] = 32'h4444_4444;
        mem_b[8'hFF] = 32'hA5A5_A5A5;

        rst_n = 1'b0;
        req0 = 0; we0 = 0; addr0 = 0; wdata0 = 0;
        req1 = 0; we1 = 0; addr1 = 0; wdata1 = 0;
        b_req0 = 0; b_we0 = 0; b_addr0 = 0; b_wdata0 = 0;
        b_req1 = 0; b_we1 = 0; b_addr1 = 0; b_wdata1 = 0;
`ifdef DMEM_ARB_STATS_EN
        stat_clr = 1'b0;
`endif

        // ---- reset state ----
        step();
        chk("rst_gnt", {30'd0, gnt1, gnt0}, 32'd0);
        chk("rst_rvalid", {30'd0, rvalid1, rvalid0}, 32'd0);
        chk("rst_bram_we", {31'd0, bram_we}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_bram_addr", {16'd0, bram_addr}, 32'd0);
        rst_n = 1'b1;

        // ---- port 0 write then read 0x0010 ----
        req0 = 1; we0 = 1; addr0 = 16'h0010; wdata0 = 32'hDEAD_BEEF;
        step();
        chk("wr_gnt0", {31'd0, gnt0}, 32'd1);
        chk("wr_gnt1", {31'd0, gnt1}, 32'd0);
        chk("wr_bram_we", {31'd0, bram_we}, 32'd1);
        chk("wr_bram_addr", {16'd0, bram_addr}, 32'h10);
        chk("wr_bram_din", bram_din, 32'hDEAD_BEEF);
        chk("wr_busy", {31'd0, busy}, 32'd1);
        req0 = 0; we0 = 0;
        step();
        chk("wr_bram_we_1cyc", {31'd0, bram_we}, 32'd0);
        chk("wr_gnt0_drop", {31'd0, gnt0}, 32'd0);
        chk("wr_idle_2cyc", {31'd0, busy}, 32'd0);
        req0 = 1; we0 = 0; addr0 = 16'h0010;
        step();
        chk("rd_gnt0", {31'd0, gnt0}, 32'd1);
        chk("rd_bram_we", {31'd0, bram_we}, 32'd0);
        req0 = 0;
        step();
        chk("rd_rvalid0_early", {31'd0, rvalid0}, 32'd0);
        step();
        chk("rd_rvalid0", {31'd0, rvalid0}, 32'd1);
        chk("rd_rvalid1", {31'd0, rvalid1}, 32'd0);
        chk("rd_rdata", rdata, 32'hDEAD_BEEF);
        step();
        chk("rd_rvalid0_pulse", {31'd0, rvalid0}, 32'd0);
        chk("rd_rdata_hold", rdata, 32'hDEAD_BEEF);
        chk("rd_busy_done", {31'd0, busy}, 32'd0);

        // ---- tie after reset: port 0 first, then port 1 ----
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        req0 = 1; addr0 = 16'h0001; req1 = 1; addr1 = 16'h0002;
        step();
        chk("tie_gnt0", {31'd0, gnt0}, 32'd1);
        chk("tie_gnt1_low", {31'd0, gnt1}, 32'd0);
        req0 = 0;
        step();
        step();
        chk("tie_rvalid0", {30'd0, rvalid1, rvalid0}, 32'd1);
        chk("tie_rdata0", rdata, 32'h1111_1111);
        step();
        chk("tie_gnt1", {30'd0, gnt1, gnt0}, 32'd2);
        req1 = 0;
        step();
        step();
        chk("tie_rvalid1", {30'd0, rvalid1, rvalid0}, 32'd2);
        chk("tie_rdata1", rdata, 32'h2222_2222);

        // ---- both ports hold req for 8 accesses: strict alternation, no gaps ----
        req0 = 1; addr0 = 16'h0003; req1 = 1; addr1 = 16'h0004;
        for (int k = 0; k < 8; k++) begin
            step();
            chk($sformatf("rr_gnt_%0d", k), {30'd0, gnt1, gnt0}, (k % 2 == 0) ? 32'd1 : 32'd2);
            step();
            chk($sformatf("rr_gap_%0d", k), {30'd0, gnt1, gnt0}, 32'd0);
            step();
            chk($sformatf("rr_rvalid_%0d", k), {30'd0, rvalid1, rvalid0},
                (k % 2 == 0) ? 32'd1 : 32'd2);
            chk($sformatf("rr_rdata_%0d", k), rdata,
                (k % 2 == 0) ? 32'h3333_3333 : 32'h4444_4444);
        end
        req0 = 0; req1 = 0;
        step();
        chk("rr_idle", {31'd0, busy}, 32'd0);

        // ---- READ_LATENCY=3: port 1 reads 0x00FF ----
        b_req1 = 1; b_addr1 = 16'h00FF;
        step();
        chk("l3_gnt1", {30'd0, b_gnt1, b_gnt0}, 32'd2);
        chk("l3_busy_gnt", {31'd0, b_busy}, 32'd1);
        b_req1 = 0;
        for (int k = 0; k < 3; k++) begin
            step();
            chk($sformatf("l3_wait_busy_%0d", k), {31'd0, b_busy}, 32'd1);
            chk($sformatf("l3_wait_rvalid_%0d", k), {30'd0, b_rvalid1, b_rvalid0}, 32'd0);
        end
        step();
        chk("l3_rvalid1", {30'd0, b_rvalid1, b_rvalid0}, 32'd2);
        chk("l3_rdata", b_rdata, 32'hA5A5_A5A5);
        chk("l3_busy_done", {31'd0, b_busy}, 32'd1);
        step();
        chk("l3_rvalid1_drop", {31'd0, b_rvalid1}, 32'd0);
        chk("l3_idle", {31'd0, b_busy}, 32'd0);

        // ---- reset in the cycle after gnt0 for a read ----
        req0 = 1; we0 = 0; addr0 = 16'h0001;
        step();
        chk("ab_gnt0", {31'd0, gnt0}, 32'd1);
        req0 = 0;
        rst_n = 1'b0;
        #1;
        chk("ab_gnt0_clr", {31'd0, gnt0}, 32'd0);
        chk("ab_bram_we", {31'd0, bram_we}, 32'd0);
        chk("ab_rvalid0", {31'd0, rvalid0}, 32'd0);
        chk("ab_busy", {31'd0, busy}, 32'd0);
        step();
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            chk($sformatf("ab_no_stale_%0d", k), {29'd0, busy, rvalid1, rvalid0}, 32'd0);
        end

`ifdef DMEM_ARB_STATS_EN
        // ---- statistics: 3 contended rounds of 2 accesses ----
        chk("st_rst", {stat_gnt0, stat_conflict}, 32'd0);
        for (int r = 0; r < 3; r++) begin
            req0 = 1; addr0 = 16'h0001; req1 = 1; addr1 = 16'h0002;
            step();
            req0 = 0;
            step();
            step();
            step();
            req1 = 0;
            step();
            step();
        end
        step();
        chk("st_conflict", {16'd0, stat_conflict}, 32'd3);
        chk("st_gnt0", {16'd0, stat_gnt0}, 32'd3);
        chk("st_gnt1", {16'd0, stat_gnt1}, 32'd3);
        stat_clr = 1'b1;
        step();
        stat_clr = 1'b0;
        chk("st_clr", {stat_gnt0, stat_gnt1} | {16'd0, stat_conflict}, 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
